// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word width, memory-stage FSM encoding and SC result codes.
package cpu_types_pkg;

  localparam int CPU_WORD_W = 32;
  localparam int CPU_OFF_W  = 2;

  typedef logic [CPU_WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  localparam int unsigned SC_SUCCESS = 0;
  localparam int unsigned SC_FAIL    = 1;

endpackage

// File: rtl/link_reg.sv
// LR/SC reservation: set when an LR completes, cleared by SC, matching store, matching snoop or halt.
// Updates on the clock edge; o_match is combinational and already excludes a same-cycle snoop/halt.
module link_reg #(
  parameter int WORD_W = 32,
  parameter int OFF_W  = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              i_set,
  input  logic              i_clr,
  input  logic [WORD_W-1:0] i_addr,
  input  logic              i_snoop_inv,
  input  logic [WORD_W-1:0] i_snoop_addr,
  input  logic              i_halt,
  output logic              o_match,
  output logic              o_link_valid
);

  localparam logic [WORD_W-1:0] WORD_MASK = {{(WORD_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  logic              r_link_valid;
  logic [WORD_W-1:0] r_link_addr;
  logic              w_addr_eq;
  logic              w_snoop_old;
  logic              w_snoop_new;

  assign w_addr_eq   = ((r_link_addr ^ i_addr) & WORD_MASK) == '0;
  assign w_snoop_old = i_snoop_inv & (((r_link_addr ^ i_snoop_addr) & WORD_MASK) == '0);
  // A snoop landing with the LR completion must hit the address being linked.
  assign w_snoop_new = i_snoop_inv & (((i_addr ^ i_snoop_addr) & WORD_MASK) == '0);

  assign o_match      = r_link_valid & w_addr_eq & ~w_snoop_old & ~i_halt;
  assign o_link_valid = r_link_valid;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_link_valid <= 1'b0;
      r_link_addr  <= '0;
    end else if (i_set) begin
      r_link_valid <= ~(w_snoop_new | i_halt);
      r_link_addr  <= i_addr;
    end else if (i_clr | w_snoop_old | i_halt) begin
      r_link_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: runs the dcache request/dhit handshake, captures load/SC results, tracks LR/SC.
// Stall is 1 cycle plus dcache latency (1 cycle for a failed SC); result holds in DONE until advance.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = CPU_WORD_W,
  parameter int OFF_W  = CPU_OFF_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              memREN_i,
  input  logic              memWEN_i,
  input  logic              lr_i,
  input  logic              sc_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] store_i,
  input  logic              advance,
  input  logic              flush,
  input  logic              halt_i,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [WORD_W-1:0] dmemload_o,
  output logic              link_valid
);

  mem_state_t        r_state;
  mem_state_t        w_state_nxt;
  logic              r_flush_pend;
  logic              w_flush_pend_nxt;
  logic [WORD_W-1:0] r_load_q;
  logic [WORD_W-1:0] w_load_q_nxt;
  logic              r_req_ren;
  logic              r_req_wen;
  logic              r_req_lr;
  logic              r_req_sc;
  logic [WORD_W-1:0] r_req_addr;
  logic [WORD_W-1:0] r_req_store;
  logic              w_op;
  logic              w_is_sc;
  logic              w_link_match;
  logic              w_capture;
  logic              w_link_set;
  logic              w_link_clr;
  logic [WORD_W-1:0] w_cmp_addr;

  assign w_op    = memREN_i | memWEN_i;
  assign w_is_sc = memWEN_i & sc_i;
  // IDLE checks the incoming SC address; ACCESS checks the captured request.
  assign w_cmp_addr = (r_state == ACCESS) ? r_req_addr : addr_i;

  link_reg #(
    .WORD_W (WORD_W),
    .OFF_W  (OFF_W)
  ) u_link_reg (
    .CLK          (CLK),
    .nRST         (nRST),
    .i_set        (w_link_set),
    .i_clr        (w_link_clr),
    .i_addr       (w_cmp_addr),
    .i_snoop_inv  (snoop_inv),
    .i_snoop_addr (snoop_addr),
    .i_halt       (halt_i),
    .o_match      (w_link_match),
    .o_link_valid (link_valid)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_flush_pend <= 1'b0;
      r_load_q     <= '0;
      r_req_ren    <= 1'b0;
      r_req_wen    <= 1'b0;
      r_req_lr     <= 1'b0;
      r_req_sc     <= 1'b0;
      r_req_addr   <= '0;
      r_req_store  <= '0;
    end else begin
      r_flush_pend <= w_flush_pend_nxt;
      r_load_q     <= w_load_q_nxt;
      if (w_capture) begin
        r_req_ren   <= memREN_i;
        r_req_wen   <= memWEN_i;
        r_req_lr    <= memREN_i & lr_i;
        r_req_sc    <= w_is_sc;
        r_req_addr  <= addr_i;
        r_req_store <= store_i;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_flush_pend_nxt = r_flush_pend;
    w_load_q_nxt     = r_load_q;
    w_capture        = 1'b0;
    w_link_set       = 1'b0;
    w_link_clr       = 1'b0;
    mem_stall        = 1'b0;
    dmemREN          = 1'b0;
    dmemWEN          = 1'b0;
    dmemaddr         = '0;
    dmemstore        = '0;
    case (r_state)
      IDLE: begin
        mem_stall = w_op & ~flush;
        if (w_op && !flush) begin
          if (w_is_sc && !w_link_match) begin
            w_state_nxt  = DONE;
            w_load_q_nxt = WORD_W'(SC_FAIL);
          end else begin
            w_state_nxt = ACCESS;
            w_capture   = 1'b1;
          end
        end
      end
      ACCESS: begin
        mem_stall = 1'b1;
        dmemREN   = r_req_ren;
        dmemWEN   = r_req_wen;
        dmemaddr  = r_req_addr;
        dmemstore = r_req_store;
        if (dhit) begin
          w_flush_pend_nxt = 1'b0;
          // A squashed op still had to finish in the cache, but leaves no trace here.
          if (r_flush_pend || flush) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DONE;
            if (r_req_ren) begin
              w_load_q_nxt = dmemload;
            end else if (r_req_sc) begin
              w_load_q_nxt = WORD_W'(SC_SUCCESS);
            end
            w_link_set = r_req_lr;
            w_link_clr = r_req_sc | (r_req_wen & w_link_match);
          end
        end else if (flush) begin
          w_flush_pend_nxt = 1'b1;
        end
      end
      DONE: begin
        if (advance || flush) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign dmemload_o = r_load_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: reference model at transaction level, dcache responder, decoupled monitor.
module tb_mem_stage;

  localparam int OP_LD = 0;
  localparam int OP_ST = 1;
  localparam int OP_LR = 2;
  localparam int OP_SC = 3;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        memREN_i = 1'b0;
  logic        memWEN_i = 1'b0;
  logic        lr_i = 1'b0;
  logic        sc_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] store_i = '0;
  logic        advance = 1'b0;
  logic        flush = 1'b0;
  logic        halt_i = 1'b0;
  logic        dhit = 1'b0;
  logic [31:0] dmemload = '0;
  logic        snoop_inv = 1'b0;
  logic [31:0] snoop_addr = '0;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        mem_stall;
  logic [31:0] dmemload_o;
  logic        link_valid;

  mem_stage dut (
    .CLK(CLK), .nRST(nRST), .memREN_i(memREN_i), .memWEN_i(memWEN_i), .lr_i(lr_i), .sc_i(sc_i),
    .addr_i(addr_i), .store_i(store_i), .advance(advance), .flush(flush), .halt_i(halt_i),
    .dhit(dhit), .dmemload(dmemload), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .dmemload_o(dmemload_o), .link_valid(link_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] load;
    int          stall;
    int          ren;
    int          wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic        link;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];
  int          n_vec = 0;
  int          n_err = 0;
  int          tb_lat = 1;
  logic        tb_busy = 1'b0;
  logic        tb_snoop_hit = 1'b0;
  logic [31:0] tb_snoop_hit_addr = '0;
  logic        tb_gap_snoop = 1'b0;
  logic [31:0] tb_gap_snoop_addr = '0;
  logic        m_link_valid = 1'b0;
  logic [31:0] m_link_addr = '0;
  logic [31:0] m_load = '0;
  int          rsp_cnt = 0;
  int          mon_stall = 0;
  int          mon_ren = 0;
  int          mon_wen = 0;
  int          mon_bad = 0;

  function automatic logic [31:0] wkey(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (wkey(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(wkey(a))) return ref_mem[wkey(a)];
    return dflt(a);
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    if (dev_mem.exists(wkey(a))) return dev_mem[wkey(a)];
    return dflt(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  // Dcache: hit after tb_lat request cycles; also owns the snoop wires.
  initial begin
    forever begin
      @(negedge CLK);
      dhit       = 1'b0;
      dmemload   = $urandom();
      snoop_inv  = tb_gap_snoop;
      snoop_addr = tb_gap_snoop_addr;
      if (!nRST) begin
        rsp_cnt = 0;
      end else if (dmemREN || dmemWEN) begin
        rsp_cnt++;
        if (rsp_cnt >= tb_lat) begin
          dhit    = 1'b1;
          rsp_cnt = 0;
          if (dmemREN) dmemload = dev_rd(dmemaddr);
          if (dmemWEN) dev_mem[wkey(dmemaddr)] = dmemstore;
          if (tb_snoop_hit) begin
            snoop_inv  = 1'b1;
            snoop_addr = tb_snoop_hit_addr;
          end
        end
      end else begin
        rsp_cnt = 0;
      end
    end
  end

  // Monitor: accumulates per-op observations, compares when the stall drops.
  always @(negedge CLK) begin
    if (!tb_busy) begin
      mon_stall = 0; mon_ren = 0; mon_wen = 0; mon_bad = 0;
    end else begin
      if (mem_stall) mon_stall++;
      if (dmemREN) mon_ren++;
      if (dmemWEN) mon_wen++;
      if ((dmemREN || dmemWEN) && exp_q.size() > 0 &&
          (dmemaddr !== exp_q[0].addr || (dmemWEN && dmemstore !== exp_q[0].store))) mon_bad++;
      if (!mem_stall) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL completion: got a completion, expected none pending");
        end else begin
          mon_e = exp_q.pop_front();
          check("dmemload_o", dmemload_o, mon_e.load);
          check("stall_cycles", 32'(mon_stall), 32'(mon_e.stall));
          check("ren_cycles", 32'(mon_ren), 32'(mon_e.ren));
          check("wen_cycles", 32'(mon_wen), 32'(mon_e.wen));
          check("req_addr_data_errors", 32'(mon_bad), 32'd0);
          check("link_valid", 32'(link_valid), 32'(mon_e.link));
        end
        mon_stall = 0; mon_ren = 0; mon_wen = 0; mon_bad = 0;
      end
    end
  end

  // Called at posedge+1: model the op, queue the expectation, drive it until done, then advance.
  task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] sdat, input int lat);
    exp_t e;
    int   t;
    e.addr  = addr;
    e.store = sdat;
    e.ren   = 0;
    e.wen   = 0;
    e.stall = 1 + lat;
    e.load  = m_load;
    case (kind)
      OP_LD: begin
        e.load = ref_rd(addr);
        e.ren  = lat;
      end
      OP_ST: begin
        e.wen = lat;
        ref_mem[wkey(addr)] = sdat;
        if (m_link_valid && wkey(addr) == wkey(m_link_addr)) m_link_valid = 1'b0;
      end
      OP_LR: begin
        e.load       = ref_rd(addr);
        e.ren        = lat;
        m_link_addr  = addr;
        m_link_valid = !(tb_snoop_hit && wkey(tb_snoop_hit_addr) == wkey(addr));
      end
      default: begin
        if (m_link_valid && wkey(addr) == wkey(m_link_addr)) begin
          e.load = 32'd0;
          e.wen  = lat;
          ref_mem[wkey(addr)] = sdat;
          m_link_valid = 1'b0;
        end else begin
          e.load  = 32'd1;
          e.stall = 1;
        end
      end
    endcase
    e.link = m_link_valid;
    m_load = e.load;
    exp_q.push_back(e);
    tb_lat   = lat;
    memREN_i = (kind == OP_LD) || (kind == OP_LR);
    memWEN_i = (kind == OP_ST) || (kind == OP_SC);
    lr_i     = (kind == OP_LR);
    sc_i     = (kind == OP_SC);
    addr_i   = addr;
    store_i  = sdat;
    tb_busy  = 1'b1;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (mem_stall && t < 64);
    if (mem_stall) begin
      n_vec++; n_err++;
      $display("FAIL op_timeout: got mem_stall=1 after %0d cycles, expected completion", t);
      finish_run();
    end
    advance = 1'b1;
    @(posedge CLK);
    #1;
    advance  = 1'b0;
    memREN_i = 1'b0;
    memWEN_i = 1'b0;
    lr_i     = 1'b0;
    sc_i     = 1'b0;
    addr_i   = '0;
    store_i  = '0;
    tb_busy  = 1'b0;
  endtask

  // Idle cycle with an optional snoop (kind 1) or halt (kind 2).
  task automatic gap(input int kind, input logic [31:0] a);
    if (kind == 1) begin
      tb_gap_snoop      = 1'b1;
      tb_gap_snoop_addr = a;
      if (m_link_valid && wkey(a) == wkey(m_link_addr)) m_link_valid = 1'b0;
    end
    if (kind == 2) begin
      halt_i       = 1'b1;
      m_link_valid = 1'b0;
    end
    @(posedge CLK);
    #1;
    tb_gap_snoop = 1'b0;
    halt_i       = 1'b0;
    check("link_after_gap", 32'(link_valid), 32'(m_link_valid));
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dmemREN"}, 32'(dmemREN), 32'd0);
    check({tag, "_dmemWEN"}, 32'(dmemWEN), 32'd0);
    check({tag, "_dmemaddr"}, dmemaddr, 32'd0);
    check({tag, "_dmemstore"}, dmemstore, 32'd0);
    check({tag, "_mem_stall"}, 32'(mem_stall), 32'd0);
    check({tag, "_dmemload_o"}, dmemload_o, 32'd0);
    check({tag, "_link_valid"}, 32'(link_valid), 32'd0);
  endtask

  initial begin
    int ren;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);
    check_all_zero("reset");
    @(posedge CLK);
    #1;

    ref_mem[32'h100] = 32'hDEAD_BEEF;
    dev_mem[32'h100] = 32'hDEAD_BEEF;
    do_op(OP_LD, 32'h100, 32'h0, 3);

    do_op(OP_LR, 32'h200, 32'h0, 2);
    do_op(OP_SC, 32'h203, 32'h5, 2);

    do_op(OP_LR, 32'h200, 32'h0, 1);
    gap(1, 32'h200);
    do_op(OP_SC, 32'h200, 32'h7, 2);

    tb_snoop_hit      = 1'b1;
    tb_snoop_hit_addr = 32'h200;
    do_op(OP_LR, 32'h200, 32'h0, 2);
    tb_snoop_hit = 1'b0;
    do_op(OP_SC, 32'h200, 32'h9, 1);

    // Flush in the second ACCESS cycle of a load; hit lands two cycles later.
    tb_lat   = 4;
    memREN_i = 1'b1;
    addr_i   = 32'h300;
    ren      = 0;
    @(posedge CLK); #1;
    @(negedge CLK); ren += 32'(dmemREN);
    @(posedge CLK); #1; flush = 1'b1;
    @(negedge CLK); ren += 32'(dmemREN);
    check("flush_stall", 32'(mem_stall), 32'd1);
    @(posedge CLK); #1; flush = 1'b0;
    @(negedge CLK); ren += 32'(dmemREN);
    @(posedge CLK); #1;
    @(negedge CLK); ren += 32'(dmemREN);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("flush_ren_cycles", 32'(ren), 32'd4);
    check("flush_back_in_idle", 32'(mem_stall), 32'd1);
    check("flush_no_request", 32'(dmemREN), 32'd0);
    check("flush_load_kept", dmemload_o, m_load);
    check("flush_link_kept", 32'(link_valid), 32'(m_link_valid));
    memREN_i = 1'b0;
    addr_i   = '0;
    @(posedge CLK); #1;

    // Reset in the middle of an outstanding load, after an ignored between-edge pulse.
    do_op(OP_LR, 32'h400, 32'h0, 1);
    tb_lat   = 10;
    memREN_i = 1'b1;
    addr_i   = 32'h500;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    #1 nRST = 1'b0;
    #2 nRST = 1'b1;
    @(negedge CLK);
    check("async_pulse_ren", 32'(dmemREN), 32'd1);
    check("async_pulse_link", 32'(link_valid), 32'd1);
    nRST     = 1'b0;
    memREN_i = 1'b0;
    addr_i   = '0;
    @(posedge CLK); #1 nRST = 1'b1;
    @(negedge CLK);
    check_all_zero("midreset");
    m_link_valid = 1'b0;
    m_load       = '0;
    @(posedge CLK); #1;
    do_op(OP_LD, 32'h500, 32'h0, 2);

    for (int i = 0; i < 200; i++) begin
      int          k;
      int          g;
      logic [31:0] a;
      k = int'($urandom_range(0, 3));
      a = 32'h1000 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
      if (k == OP_SC && $urandom_range(0, 1) == 1) a = {m_link_addr[31:2], 2'($urandom_range(0, 3))};
      do_op(k, a, $urandom(), int'($urandom_range(1, 4)));
      g = int'($urandom_range(0, 5));
      if (g == 1) gap(1, 32'h1000 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3));
      else if (g == 2) gap(2, 32'h0);
      else if (g == 3) gap(0, 32'h0);
    end

    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL pending_expectations: got %0d left, expected 0", exp_q.size());
    end
    finish_run();
  end

endmodule
